imem_port_arbiter: RTL and testbench

- Shares the byte-addressed instruction memory (2^20 bytes, little-endian 32-bit words, combinational read) between two requesters.
- Requester F is the pipeline fetch stage (reads). Requester L is the boot/debug loader (word writes with byte enables).
- Drives the memory's single address/write port, registers read data and write completion, and applies anti-starvation arbitration.
- Sits between the IF stage and the instruction memory.

---
 rtl/imem_port_arbiter.sv | 138 +++++++++++++
 tb/tb_imem_port_arbiter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/imem_port_arbiter.sv
// Shares the single instruction-memory port between the fetch stage and the
// boot/debug loader, with a starvation counter that forces a loader grant.
module imem_port_arbiter #(
    parameter int unsigned XLEN       = 2,
    parameter int unsigned MEM_BYTES  = 1 << 20,
    parameter int unsigned STARVE_MAX = 4,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_f_req,
    input  logic [(1 << (XLEN+4))-1:0]   i_f_adr,
    output logic                         o_f_gnt,
    output logic                         o_f_rvalid,
    output logic [31:0]                  o_f_instr,
    output logic                         o_f_err,
    input  logic                         i_flush,
    input  logic                         i_l_req,
    input  logic [(1 << (XLEN+4))-1:0]   i_l_adr,
    input  logic [31:0]                  i_l_wdata,
    input  logic [3:0]                   i_l_be,
    output logic                         o_l_gnt,
    output logic                         o_l_done,
    output logic                         o_l_err,
    output logic [(1 << (XLEN+4))-1:0]   o_mem_adr,
    output logic                         o_mem_we,
    output logic [3:0]                   o_mem_be,
    output logic [31:0]                  o_mem_wdata,
    input  logic [31:0]                  i_mem_rdata,
    output logic [3:0]                   o_starve_cnt
);

    localparam int unsigned AW = 1 << (XLEN + 4);
    localparam logic [AW-1:0] LAST_WORD  = AW'(MEM_BYTES - 4);
    localparam logic [3:0]    STARVE_LIM = 4'(STARVE_MAX);

    typedef enum logic {ARB_F, ARB_L} arb_e;

    arb_e        state_q, state_d;
    logic [3:0]  starve_q, starve_d;
    logic        f_rvalid_q, f_rvalid_d;
    logic [31:0] f_instr_q, f_instr_d;
    logic        f_err_q, f_err_d;
    logic        l_done_q, l_done_d;
    logic        l_err_q, l_err_d;

    logic f_gnt, l_gnt, f_legal, l_legal;

    assign f_legal = (i_f_adr[1:0] == 2'b00) && (i_f_adr <= LAST_WORD);
    assign l_legal = (i_l_adr[1:0] == 2'b00) && (i_l_adr <= LAST_WORD);

    // Grant selection, starvation counter and next-state/response logic.
    always_comb begin
        f_gnt      = 1'b0;
        l_gnt      = 1'b0;
        starve_d   = 4'd0;
        state_d    = state_q;
        f_rvalid_d = 1'b0;
        f_instr_d  = f_instr_q;
        f_err_d    = f_err_q;
        l_done_d   = 1'b0;
        l_err_d    = l_err_q;

        if (state_q == ARB_L) begin
            l_gnt = i_l_req;
            f_gnt = i_f_req && !i_l_req;
        end else begin
            f_gnt = i_f_req;
            l_gnt = i_l_req && !i_f_req;
        end

        if (i_l_req && !l_gnt) begin
            starve_d = (starve_q >= STARVE_LIM) ? STARVE_LIM : starve_q + 4'd1;
        end

        // Switch in the same edge the counter saturates so the forced grant lands next cycle.
        case (state_q)
            ARB_F:   if (starve_d == STARVE_LIM) state_d = ARB_L;
            ARB_L:   if (l_gnt || !i_l_req)      state_d = ARB_F;
            default: state_d = ARB_F;
        endcase

        if (f_gnt) begin
            f_rvalid_d = 1'b1;
            f_instr_d  = f_legal ? i_mem_rdata : NOP_INSTR;
            f_err_d    = !f_legal;
        end

        if (l_gnt) begin
            l_done_d = 1'b1;
            l_err_d  = !l_legal;
        end
    end

    always_comb begin
        o_mem_adr   = i_f_adr;
        o_mem_we    = 1'b0;
        o_mem_be    = 4'b0000;
        o_mem_wdata = 32'd0;
        if (l_gnt) begin
            o_mem_adr   = i_l_adr;
            o_mem_we    = l_legal;
            o_mem_be    = i_l_be;
            o_mem_wdata = i_l_wdata;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= ARB_F;
            starve_q   <= 4'd0;
            f_rvalid_q <= 1'b0;
            f_instr_q  <= 32'd0;
            f_err_q    <= 1'b0;
            l_done_q   <= 1'b0;
            l_err_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            starve_q   <= starve_d;
            f_rvalid_q <= f_rvalid_d;
            f_instr_q  <= f_instr_d;
            f_err_q    <= f_err_d;
            l_done_q   <= l_done_d;
            l_err_q    <= l_err_d;
        end
    end

    // Flush masks the response that is already registered for this cycle.
    assign o_f_rvalid   = f_rvalid_q && !i_flush;
    assign o_f_instr    = f_instr_q;
    assign o_f_err      = f_err_q;
    assign o_f_gnt      = f_gnt;
    assign o_l_gnt      = l_gnt;
    assign o_l_done     = l_done_q;
    assign o_l_err      = l_err_q;
    assign o_starve_cnt = starve_q;

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed bench for imem_port_arbiter with a behavioural memory and a response scoreboard.
module tb_imem_port_arbiter;

    localparam int unsigned AW = 64;

    logic          i_clk = 1'b0;
    logic          i_rst;
    logic          i_f_req;
    logic [AW-1:0] i_f_adr;
    logic          o_f_gnt;
    logic          o_f_rvalid;
    logic [31:0]   o_f_instr;
    logic          o_f_err;
    logic          i_flush;
    logic          i_l_req;
    logic [AW-1:0] i_l_adr;
    logic [31:0]   i_l_wdata;
    logic [3:0]    i_l_be;
    logic          o_l_gnt;
    logic          o_l_done;
    logic          o_l_err;
    logic [AW-1:0] o_mem_adr;
    logic          o_mem_we;
    logic [3:0]    o_mem_be;
    logic [31:0]   o_mem_wdata;
    logic [31:0]   i_mem_rdata;
    logic [3:0]    o_starve_cnt;

    imem_port_arbiter dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_f_req      (i_f_req),
        .i_f_adr      (i_f_adr),
        .o_f_gnt      (o_f_gnt),
        .o_f_rvalid   (o_f_rvalid),
        .o_f_instr    (o_f_instr),
        .o_f_err      (o_f_err),
        .i_flush      (i_flush),
        .i_l_req      (i_l_req),
        .i_l_adr      (i_l_adr),
        .i_l_wdata    (i_l_wdata),
        .i_l_be       (i_l_be),
        .o_l_gnt      (o_l_gnt),
        .o_l_done     (o_l_done),
        .o_l_err      (o_l_err),
        .o_mem_adr    (o_mem_adr),
        .o_mem_we     (o_mem_we),
        .o_mem_be     (o_mem_be),
        .o_mem_wdata  (o_mem_wdata),
        .i_mem_rdata  (i_mem_rdata),
        .o_starve_cnt (o_starve_cnt)
    );

    always #5 i_clk = ~i_clk;

    logic [31:0] mem [0:262143];
    assign i_mem_rdata = mem[o_mem_adr[19:2]];

    always @(posedge i_clk) begin
        if (o_mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (o_mem_be[b]) mem[o_mem_adr[19:2]][8*b +: 8] <= o_mem_wdata[8*b +: 8];
            end
        end
    end

    typedef struct {
        logic [31:0] instr;
        logic        err;
    } fexp_t;

    fexp_t f_q[$];
    logic  l_q[$];
    int    n_chk  = 0;
    int    n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One cycle: drive at the falling edge, check everything visible before the next rising edge.
    task automatic step(input logic freq, input logic [AW-1:0] fadr,
                        input logic lreq, input logic [AW-1:0] ladr,
                        input logic [31:0] wd, input logic [3:0] be, input logic flush,
                        input logic efg, input logic elg, input logic [31:0] einstr,
                        input logic eferr, input logic elerr, input logic [3:0] ecnt);
        fexp_t fe;
        logic  le;
        @(negedge i_clk);
        i_f_req   = freq;
        i_f_adr   = fadr;
        i_l_req   = lreq;
        i_l_adr   = ladr;
        i_l_wdata = wd;
        i_l_be    = be;
        i_flush   = flush;
        #1;
        if (f_q.size() > 0 && !flush) begin
            fe = f_q.pop_front();
            chk("f_rvalid", 64'(o_f_rvalid), 64'd1);
            chk("f_instr", 64'(o_f_instr), 64'(fe.instr));
            chk("f_err", 64'(o_f_err), 64'(fe.err));
        end else begin
            chk("f_rvalid_idle", 64'(o_f_rvalid), 64'd0);
            f_q.delete();
        end
        if (l_q.size() > 0) begin
            le = l_q.pop_front();
            chk("l_done", 64'(o_l_done), 64'd1);
            chk("l_err", 64'(o_l_err), 64'(le));
        end else begin
            chk("l_done_idle", 64'(o_l_done), 64'd0);
        end
        chk("f_gnt", 64'(o_f_gnt), 64'(efg));
        chk("l_gnt", 64'(o_l_gnt), 64'(elg));
        chk("starve_cnt", 64'(o_starve_cnt), 64'(ecnt));
        chk("mem_adr", o_mem_adr, elg ? ladr : fadr);
        chk("mem_we", 64'(o_mem_we), 64'(elg && !elerr));
        chk("mem_be", 64'(o_mem_be), elg ? 64'(be) : 64'd0);
        chk("mem_wdata", 64'(o_mem_wdata), elg ? 64'(wd) : 64'd0);
        if (efg) f_q.push_back(fexp_t'{instr: einstr, err: eferr});
        if (elg) l_q.push_back(elerr);
    endtask

    task automatic idle();
        step(1'b0, '0, 1'b0, '0, 32'd0, 4'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 4'd0);
    endtask

    initial begin
        for (int i = 0; i < 262144; i++) mem[i] = 32'd0;
        mem[0]      = 32'h0050_0093;
        mem[1]      = 32'h0010_0113;
        mem[2]      = 32'h0020_81B3;
        mem[4]      = 32'h0BAD_C0DE;
        mem[262143] = 32'hCAFE_F00D;

        i_rst = 1'b1; i_f_req = 1'b0; i_f_adr = '0; i_flush = 1'b0;
        i_l_req = 1'b0; i_l_adr = '0; i_l_wdata = 32'd0; i_l_be = 4'd0;
        #1;
        chk("rst_f_rvalid", 64'(o_f_rvalid), 64'd0);
        chk("rst_f_instr", 64'(o_f_instr), 64'd0);
        chk("rst_f_err", 64'(o_f_err), 64'd0);
        chk("rst_l_done", 64'(o_l_done), 64'd0);
        chk("rst_l_err", 64'(o_l_err), 64'd0);
        chk("rst_starve", 64'(o_starve_cnt), 64'd0);
        @(negedge i_clk);
        i_rst = 1'b0;

        // Reset in the middle of a fetch with the loader already waiting.
        step(1'b1, 64'h10, 1'b1, 64'h40, 32'h1111_1111, 4'hF, 1'b0, 1'b1, 1'b0, 32'h0BAD_C0DE, 1'b0, 1'b0, 4'd0);
        @(posedge i_clk);
        #1;
        chk("pre_rst_rvalid", 64'(o_f_rvalid), 64'd1);
        chk("pre_rst_starve", 64'(o_starve_cnt), 64'd1);
        i_rst = 1'b1;
        #1;
        chk("mid_rst_rvalid", 64'(o_f_rvalid), 64'd0);
        chk("mid_rst_instr", 64'(o_f_instr), 64'd0);
        chk("mid_rst_starve", 64'(o_starve_cnt), 64'd0);
        f_q.delete();
        i_f_req = 1'b0;
        i_l_req = 1'b0;
        @(negedge i_clk);
        i_rst = 1'b0;

        // Fetch-only stream.
        step(1'b1, 64'h0, 1'b0, '0, 32'd0, 4'd0, 1'b0, 1'b1, 1'b0, 32'h0050_0093, 1'b0, 1'b0, 4'd0);
        step(1'b1, 64'h4, 1'b0, '0, 32'd0, 4'd0, 1'b0, 1'b1, 1'b0, 32'h0010_0113, 1'b0, 1'b0, 4'd0);
        step(1'b1, 64'h8, 1'b0, '0, 32'd0, 4'd0, 1'b0, 1'b1, 1'b0, 32'h0020_81B3, 1'b0, 1'b0, 4'd0);
        idle();

        // Starvation: loader forced through on the fifth contended cycle.
        for (int c = 0; c < 4; c++) begin
            step(1'b1, 64'h0, 1'b1, 64'h40, 32'h1234_5678, 4'hF, 1'b0, 1'b1, 1'b0, 32'h0050_0093, 1'b0, 1'b0, 4'(c));
        end
        step(1'b1, 64'h0, 1'b1, 64'h40, 32'h1234_5678, 4'hF, 1'b0, 1'b0, 1'b1, 32'd0, 1'b0, 1'b0, 4'd4);
        step(1'b1, 64'h0, 1'b0, '0, 32'd0, 4'd0, 1'b0, 1'b1, 1'b0, 32'h0050_0093, 1'b0, 1'b0, 4'd0);
        idle();

        // Write-then-read, full word then a single byte lane.
        step(1'b0, '0, 1'b1, 64'h20, 32'hDEAD_BEEF, 4'b1111, 1'b0, 1'b0, 1'b1, 32'd0, 1'b0, 1'b0, 4'd0);
        step(1'b1, 64'h20, 1'b0, '0, 32'd0, 4'd0, 1'b0, 1'b1, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0, 4'd0);
        step(1'b0, '0, 1'b1, 64'h20, 32'h0000_00AA, 4'b0001, 1'b0, 1'b0, 1'b1, 32'd0, 1'b0, 1'b0, 4'd0);
        step(1'b1, 64'h20, 1'b0, '0, 32'd0, 4'd0, 1'b0, 1'b1, 1'b0, 32'hDEAD_BEAA, 1'b0, 1'b0, 4'd0);
        idle();

        // Address errors and the top-of-memory boundary.
        step(1'b1, 64'h6, 1'b0, '0, 32'd0, 4'd0, 1'b0, 1'b1, 1'b0, 32'h0000_0013, 1'b1, 1'b0, 4'd0);
        step(1'b1, 64'hF_FFFE, 1'b0, '0, 32'd0, 4'd0, 1'b0, 1'b1, 1'b0, 32'h0000_0013, 1'b1, 1'b0, 4'd0);
        step(1'b1, 64'hF_FFFC, 1'b0, '0, 32'd0, 4'd0, 1'b0, 1'b1, 1'b0, 32'hCAFE_F00D, 1'b0, 1'b0, 4'd0);
        step(1'b0, '0, 1'b1, 64'h10_0000, 32'h5555_5555, 4'hF, 1'b0, 1'b0, 1'b1, 32'd0, 1'b0, 1'b1, 4'd0);
        step(1'b0, '0, 1'b1, 64'h42, 32'h6666_6666, 4'hF, 1'b0, 1'b0, 1'b1, 32'd0, 1'b0, 1'b1, 4'd0);
        step(1'b0, '0, 1'b1, 64'hF_FFFC, 32'h7654_3210, 4'hF, 1'b0, 1'b0, 1'b1, 32'd0, 1'b0, 1'b0, 4'd0);
        step(1'b1, 64'hF_FFFC, 1'b0, '0, 32'd0, 4'd0, 1'b0, 1'b1, 1'b0, 32'h7654_3210, 1'b0, 1'b0, 4'd0);
        step(1'b1, 64'h40, 1'b0, '0, 32'd0, 4'd0, 1'b0, 1'b1, 1'b0, 32'h1234_5678, 1'b0, 1'b0, 4'd0);
        step(1'b1, 64'h0, 1'b0, '0, 32'd0, 4'd0, 1'b0, 1'b1, 1'b0, 32'h0050_0093, 1'b0, 1'b0, 4'd0);
        idle();

        // Flush drops the pending response but not a fetch granted in the flush cycle.
        step(1'b1, 64'h4, 1'b0, '0, 32'd0, 4'd0, 1'b0, 1'b1, 1'b0, 32'h0010_0113, 1'b0, 1'b0, 4'd0);
        step(1'b1, 64'h8, 1'b0, '0, 32'd0, 4'd0, 1'b1, 1'b1, 1'b0, 32'h0020_81B3, 1'b0, 1'b0, 4'd0);
        idle();
        idle();

        chk("scoreboard_empty", 64'(f_q.size() + l_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
